rc4_multicore_key_search: RTL

//  Parametrised successor to the single-core RC4 brute-force key counter.

---
 rtl/rc4_multicore_key_search.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rc4_multicore_key_search.sv
// Key-range dispatcher for NUM_CORES replicated RC4 crack cores: hands out keys in order,
// collects done/valid results and reports the first winning key or range exhaustion.
module rc4_multicore_key_search #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 22
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [KEY_W-1:0]           key_lo,
  input  logic [KEY_W-1:0]           key_hi,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]       core_rst,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic                       busy,
  output logic                       solved,
  output logic                       exhausted,
  output logic [KEY_W-1:0]           found_key,
  output logic [KEY_W-1:0]           current_key,
  output logic [KEY_W:0]             keys_tried
);

  localparam int CNT_W = $clog2(NUM_CORES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_DRAIN,
    S_SOLVED,
    S_EXHAUSTED
  } state_t;

  state_t               state, state_d;
  logic [NUM_CORES-1:0] core_busy;
  logic [KEY_W-1:0]     key_q [NUM_CORES];
  logic [KEY_W-1:0]     hi_q;
  logic [KEY_W-1:0]     next_key;
  logic                 all_sent;

  logic [NUM_CORES-1:0] accepted, hits, free_sel;
  logic                 any_hit, start_ok, do_abort, do_dispatch, disp_last;
  logic [KEY_W-1:0]     hit_key, disp_key;
  logic [CNT_W-1:0]     done_cnt;

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    accepted = core_done & core_busy;
    hits     = accepted & core_valid;
    any_hit  = |hits;

    hit_key  = '0;
    free_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hits[i]) hit_key = key_q[i];
      // Freed-this-cycle cores are still busy here, so reuse waits one cycle.
      if (!core_busy[i]) begin
        free_sel    = '0;
        free_sel[i] = 1'b1;
      end
    end

    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) done_cnt = done_cnt + CNT_W'(accepted[i]);

    state_d     = state;
    start_ok    = 1'b0;
    do_abort    = 1'b0;
    do_dispatch = 1'b0;
    disp_key    = next_key;

    if (abort && state != S_IDLE) begin
      do_abort = 1'b1;
      state_d  = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_SOLVED, S_EXHAUSTED: begin
          if (start && !abort) begin
            start_ok = 1'b1;
            if (key_lo > key_hi) begin
              state_d = S_EXHAUSTED;
            end else begin
              // All cores are idle here, so key_lo goes straight to core 0.
              state_d     = S_SEARCH;
              do_dispatch = 1'b1;
              disp_key    = key_lo;
            end
          end
        end
        S_SEARCH: begin
          if (any_hit)                state_d = S_SOLVED;
          else if (all_sent)          state_d = S_DRAIN;
          else if (free_sel != '0)    do_dispatch = 1'b1;
        end
        S_DRAIN: begin
          if (any_hit)                                state_d = S_SOLVED;
          else if ((core_busy & ~accepted) == '0)     state_d = S_EXHAUSTED;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Range end is detected on the key itself, never on next_key after a wrap.
    disp_last = (disp_key == (start_ok ? key_hi : hi_q));
  end

  // NOTE: state is updated only with non-blocking assignments so every register in
  // this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_busy   <= '0;
      core_start  <= '0;
      core_rst    <= '0;
      hi_q        <= '0;
      next_key    <= '0;
      all_sent    <= 1'b0;
      busy        <= 1'b0;
      solved      <= 1'b0;
      exhausted   <= 1'b0;
      found_key   <= '0;
      current_key <= '0;
      keys_tried  <= '0;
      // NOTE: the key array drives an output port that must read 0 out of reset,
      // so unlike a plain storage RAM it is reset explicitly.
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
    end else begin
      core_start <= '0;
      core_rst   <= '0;
      busy       <= (state_d == S_SEARCH) || (state_d == S_DRAIN);
      solved     <= (state_d == S_SOLVED);
      exhausted  <= (state_d == S_EXHAUSTED);

      if (do_abort) begin
        core_rst  <= core_busy;
        core_busy <= '0;
        found_key <= '0;
      end else begin
        if (start_ok) begin
          hi_q       <= key_hi;
          found_key  <= '0;
          keys_tried <= '0;
          all_sent   <= 1'b0;
        end else begin
          keys_tried <= keys_tried + (KEY_W + 1)'(done_cnt);
        end

        if (any_hit) begin
          found_key <= hit_key;
          core_rst  <= core_busy & ~accepted;
          core_busy <= '0;
        end else begin
          core_busy <= (core_busy & ~accepted) | (do_dispatch ? free_sel : '0);
        end

        if (do_dispatch) begin
          core_start  <= free_sel;
          current_key <= disp_key;
          next_key    <= disp_key + 1'b1;
          all_sent    <= disp_last;
          for (int i = 0; i < NUM_CORES; i++)
            if (free_sel[i]) key_q[i] <= disp_key;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_W +: KEY_W] = key_q[g];
  end

endmodule
